// File: rtl/count_display_if.sv
// count_display_if: groups the value input with the display and BCD outputs
// of count_display. The slave modport is the display block itself.
interface count_display_if;
    logic [7:0]  value;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [11:0] bcd;
    logic        conv_done;

    modport master (
        output value,
        input  an, seg, dp, bcd, conv_done
    );

    modport slave (
        input  value,
        output an, seg, dp, bcd, conv_done
    );
endinterface

// File: rtl/count_display.sv
// count_display: converts an 8-bit binary value to three BCD digits with a
// sequential shift-and-add-3 engine, then scans the digits onto a 4-digit
// common-anode seven-segment display with leading-zero blanking.
module count_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic            clk,
    input  logic            reset,
    count_display_if.slave  dif
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state, state_nxt;
    logic [7:0]  captured;
    logic [7:0]  bin_sr;
    logic [11:0] scratch;
    logic [11:0] adj;
    logic [2:0]  shift_cnt;
    logic [11:0] bcd_r;
    logic        done_r;

    logic [CW-1:0] rcnt;
    logic [1:0]    idx;
    logic [3:0]    dig;
    logic          lit;
    logic [3:0]    an_r;
    logic [6:0]    seg_r;

    // Active-low {g..a} pattern for one decimal digit.
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b1000000;
            4'd1:    seg_code = 7'b1111001;
            4'd2:    seg_code = 7'b0100100;
            4'd3:    seg_code = 7'b0110000;
            4'd4:    seg_code = 7'b0011001;
            4'd5:    seg_code = 7'b0010010;
            4'd6:    seg_code = 7'b0000010;
            4'd7:    seg_code = 7'b1111000;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0010000;
            default: seg_code = 7'b1111111;
        endcase
    endfunction

    // Converter state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Converter next-state: a change is only sampled while idle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (dif.value != captured) state_nxt = SHIFT;
            SHIFT:   if (shift_cnt == 3'd7)     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Add-3 correction on every scratch nibble of 5 or more before a shift.
    always_comb begin
        adj = scratch;
        for (int i = 0; i < 3; i++) begin
            if (scratch[i*4 +: 4] >= 4'd5)
                adj[i*4 +: 4] = scratch[i*4 +: 4] + 4'd3;
        end
    end

    // Converter datapath; bcd only changes on DONE so a partial result never shows.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            captured  <= 8'd0;
            bin_sr    <= 8'd0;
            scratch   <= 12'd0;
            shift_cnt <= 3'd0;
            bcd_r     <= 12'd0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (dif.value != captured) begin
                        bin_sr   <= dif.value;
                        scratch  <= 12'd0;
                        captured <= dif.value;
                    end
                end
                SHIFT: begin
                    scratch   <= {adj[10:0], bin_sr[7]};
                    bin_sr    <= {bin_sr[6:0], 1'b0};
                    shift_cnt <= shift_cnt + 3'd1;
                end
                DONE: begin
                    bcd_r     <= scratch;
                    done_r    <= 1'b1;
                    shift_cnt <= 3'd0;
                end
                default: ;
            endcase
        end
    end

    // Refresh timer: hold each slot for REFRESH_DIV cycles, then step the digit index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rcnt <= '0;
            idx  <= 2'd0;
        end else if (rcnt == CW'(REFRESH_DIV - 1)) begin
            rcnt <= '0;
            idx  <= idx + 2'd1;
        end else begin
            rcnt <= rcnt + CW'(1);
        end
    end

    // Slot selection with leading-zero blanking; ones is always lit, slot 3 never.
    always_comb begin
        dig = 4'd0;
        lit = 1'b0;
        case (idx)
            2'd0: begin dig = bcd_r[3:0];  lit = 1'b1;                 end
            2'd1: begin dig = bcd_r[7:4];  lit = |bcd_r[11:4];         end
            2'd2: begin dig = bcd_r[11:8]; lit = |bcd_r[11:8];         end
            default: begin dig = 4'd0;     lit = 1'b0;                 end
        endcase
    end

    // Registered anode/cathode drive, one cycle behind the index and bcd.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an_r  <= 4'b1111;
            seg_r <= 7'b1111111;
        end else if (lit) begin
            an_r  <= ~(4'b0001 << idx);
            seg_r <= seg_code(dig);
        end else begin
            an_r  <= 4'b1111;
            seg_r <= 7'b1111111;
        end
    end

    assign dif.an        = an_r;
    assign dif.seg       = seg_r;
    assign dif.dp        = 1'b1;
    assign dif.bcd       = bcd_r;
    assign dif.conv_done = done_r;

endmodule

// File: doc/count_display.md
# count_display

Downstream display stage for the 8-bit up/down counter: takes the live `count` byte and shows it in decimal on a 4-digit, common-anode, multiplexed seven-segment display. A sequential shift-and-add-3 converter produces three BCD digits. A refresh timer scans the digits onto shared active-low cathodes, with leading-zero blanking. The block also exposes the BCD result and a done strobe for verification and for other consumers.

## Interface
- `REFRESH_DIV`, default 100000: clock cycles each digit slot is held (1 kHz per slot at 100 MHz). Legal range is 2 and up.
- `clk` input, 1 bit: single clock. Everything is rising-edge.
- `reset` input, 1 bit: asynchronous, active-low. Asserts immediately and is released synchronously by the external reset logic.
- `value` input, 8 bits: unsigned binary to display. It is synchronous to `clk` and is the counter's `count` output.
- `an` output, 4 bits: digit anodes, active-low. `an[0]` is the ones digit, `an[3]` is the leftmost digit.
- `seg` output, 7 bits: cathodes, active-low, ordered {g,f,e,d,c,b,a}.
- `dp` output, 1 bit: decimal point. It is held at 1 (off).
- `bcd` output, 12 bits: last converted result as {hundreds, tens, ones}.
- `conv_done` output, 1 bit: one-cycle pulse when `bcd` updates.

## Operation
- Reset values:
  - `an` = 4'b1111, `seg` = 7'b1111111, `dp` = 1, `bcd` = 12'h000, `conv_done` = 0.
  - FSM is in IDLE, captured value = 0, shift counter = 0, refresh counter = 0, digit index = 0.
- Converter FSM has three states: IDLE, SHIFT, DONE.
  - **IDLE:** at each edge, compare `value` against the captured value. If they differ, load `value` into the binary shift register, clear the 12-bit scratch BCD, record `value` as captured, and go to SHIFT. Otherwise stay in IDLE.
  - **SHIFT:** each edge, for every scratch nibble ≥ 5, add 3 to that nibble. Then shift {scratch, binary} left by 1. Increment the 3-bit shift counter. After the 8th shift (counter = 7), go to DONE.
  - **DONE:** copy scratch to `bcd`, pulse `conv_done` high for exactly that cycle, clear the shift counter, and go to IDLE.
- Changes on `value` during SHIFT or DONE are not sampled. On return to IDLE, the compare against the captured value picks up any net change. Intermediate values may be skipped, but the final value is always converted.
- Output digits are always 0–9. Maximum output is 255 → 12'h255. No overflow is possible.
- Scan logic:
  - The refresh counter counts 0 to REFRESH_DIV-1, then wraps to 0.
  - On wrap, the digit index advances 0→1→2→3→0.
- Slot contents:
  - Slot 0: ones digit, always lit, even when the value is 0.
  - Slot 1: tens digit. Blanked if both hundreds and tens are 0.
  - Slot 2: hundreds digit. Blanked if hundreds is 0.
  - Slot 3: always blank.
- A blanked slot drives `an` = 4'b1111 and `seg` = 7'b1111111 for the full slot duration.
- A lit slot drives the matching `an` bit low, with the other three high.
- Segment codes ({g..a}):
  - 0: 1000000
  - 1: 1111001
  - 2: 0100100
  - 3: 0110000
  - 4: 0011001
  - 5: 0010010
  - 6: 0000010
  - 7: 1111000
  - 8: 0000000
  - 9: 0010000
- Display reads `bcd`, never the scratch register, so a partial conversion is never shown.

## Timing
- Conversion latency:
  - Edge E0: IDLE detects the change and loads the shift register.
  - Edges E1–E8: the eight shifts.
  - Edge E9: DONE. `bcd` and `conv_done` are valid from E9 and remain valid during the following cycle.
  - Conversion-to-conversion throughput is one per 10 cycles.
- `an` and `seg` are registered from the digit index and `bcd`, so they lag the index and `bcd` by one cycle.
- After `reset` deasserts, the first edge drives slot 0. With `bcd` = 0, that gives `an` = 1110 and `seg` = 1000000.
- Each slot lasts exactly REFRESH_DIV cycles. A full frame is 4 × REFRESH_DIV cycles.
- Reset asserted mid-conversion:
  - All state returns to reset values immediately (asynchronously).
  - The partial result is discarded and `conv_done` is not pulsed.
  - After release, a nonzero `value` is re-detected in IDLE and converted afresh.
- A `value` change on the same edge that DONE completes is seen in the following IDLE cycle.

## Test plan
- **Reset:** assert `reset` = 0 mid-run → `an` = 1111, `seg` = 1111111, `bcd` = 000, `conv_done` = 0, all asynchronously (before the next clock edge). Release with `value` = 0 → no `conv_done` pulse, and slot 0 shows "0" (`seg` = 1000000).
- **Full-scale conversion:** `value` 0→255 → `conv_done` one cycle, exactly 9 edges after detection, with `bcd` = 12'h255. Repeat for 0, 9, 10, 99, 100, 128, and compare against a reference divide-by-10.
- **Leading-zero blanking:** use `value` = 7 with REFRESH_DIV = 4.
  - Over 32 cycles, `an[1]`, `an[2]` and `an[3]` are never low.
  - `an[0]` is low for 4 of every 16 cycles, with `seg` = 1111000.
- **Blanking boundaries:** `value` = 105 → slots show 5, 0, 1 (tens lit despite 0), and slot 3 is blank.
- **Change mid-conversion:** `value` = 200, then 3 cycles later `value` = 17 → first `conv_done` gives `bcd` = 200, and the next `conv_done`, 10 edges later, gives `bcd` = 017.
- **Reset mid-SHIFT:** pull `reset` low at the 5th shift while `value` = 255 → no `conv_done` pulse and `bcd` = 000. After release, `bcd` = 255 with exactly one `conv_done` pulse.
